i2s_reader_frame_assembler: RTL and testbench

//  Downstream stage of the I2S reader PHY. Drains the read side of the

---
 rtl/i2s_reader_frame_assembler.sv | 158 +++++++++++++++
 tb/tb_i2s_reader_frame_assembler.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_reader_frame_assembler.sv
// Drains I2S reader ping-pong FIFO buffers and pairs left/right sample words
// into stereo frames presented on a valid/ready stream.
module i2s_reader_frame_assembler #(
   parameter int OUT_WIDTH = 24,
   parameter int DROP_W    = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_enable,
   input  logic                 i_rfifo_ready,
   output logic                 o_rfifo_activate,
   input  logic [23:0]          i_rfifo_size,
   output logic                 o_rfifo_strobe,
   input  logic [31:0]          i_rfifo_data,
   output logic                 o_frame_valid,
   input  logic                 i_frame_ready,
   output logic [OUT_WIDTH-1:0] o_left,
   output logic [OUT_WIDTH-1:0] o_right,
   output logic [31:0]          o_frame_count,
   output logic [DROP_W-1:0]    o_drop_count,
   output logic [31:0]          debug
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      READ  = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;
   logic        activate_next;
   logic        abandon;
   logic        consume;
   logic        word_is_left;
   logic        load_frame;
   logic        drop_word;
   logic        accept;
   logic [23:0] size_latched;
   logic [23:0] word_count;
   logic        left_pending;
   logic [23:0] left_sample;
   logic        unused_bits;

   assign word_is_left = ~i_rfifo_data[31];
   assign accept       = o_frame_valid & i_frame_ready;
   assign unused_bits  = ^{i_rfifo_data, left_sample};

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // A right word is only popped when the output register is free or being
   // drained this cycle; left words can always be popped into left_sample.
   always_comb begin
      state_next     = state;
      activate_next  = o_rfifo_activate;
      abandon        = 1'b0;
      consume        = 1'b0;
      o_rfifo_strobe = 1'b0;
      case (state)
         IDLE: begin
            activate_next = 1'b0;
            if (i_enable && i_rfifo_ready) begin
               activate_next = 1'b1;
               state_next    = PRIME;
            end
         end
         PRIME: begin
            if (!i_enable) begin
               abandon       = 1'b1;
               activate_next = 1'b0;
               state_next    = IDLE;
            end else if (size_latched == 24'd0) begin
               activate_next = 1'b0;
               state_next    = IDLE;
            end else begin
               state_next = READ;
            end
         end
         READ: begin
            if (!i_enable) begin
               abandon       = 1'b1;
               activate_next = 1'b0;
               state_next    = IDLE;
            end else if (word_count == size_latched) begin
               activate_next = 1'b0;
               state_next    = IDLE;
            end else if (word_is_left || !o_frame_valid || i_frame_ready) begin
               consume        = 1'b1;
               o_rfifo_strobe = 1'b1;
            end
         end
         default: begin
            activate_next = 1'b0;
            state_next    = IDLE;
         end
      endcase
   end

   assign load_frame = consume & ~word_is_left & left_pending;
   assign drop_word  = consume & (word_is_left ? left_pending : ~left_pending);

   always_ff @(posedge clk) begin
      if (!rst) begin
         o_rfifo_activate <= 1'b0;
         size_latched     <= 24'd0;
         word_count       <= 24'd0;
         left_pending     <= 1'b0;
         left_sample      <= 24'd0;
         o_frame_valid    <= 1'b0;
         o_left           <= '0;
         o_right          <= '0;
         o_frame_count    <= 32'd0;
         o_drop_count     <= '0;
      end else begin
         o_rfifo_activate <= activate_next;
         if (state == IDLE && state_next == PRIME) begin
            size_latched <= i_rfifo_size;
         end
         if (state_next != READ) begin
            word_count <= 24'd0;
         end else if (consume) begin
            word_count <= word_count + 24'd1;
         end
         // Pending left survives buffer boundaries; only abandoning a buffer clears it.
         if (abandon) begin
            left_pending <= 1'b0;
         end else if (consume && word_is_left) begin
            left_pending <= 1'b1;
            left_sample  <= i_rfifo_data[23:0];
         end else if (load_frame) begin
            left_pending <= 1'b0;
         end
         if (load_frame) begin
            o_frame_valid <= 1'b1;
            o_left        <= left_sample[23 -: OUT_WIDTH];
            o_right       <= i_rfifo_data[23 -: OUT_WIDTH];
         end else if (accept) begin
            o_frame_valid <= 1'b0;
         end
         if (accept) begin
            o_frame_count <= o_frame_count + 32'd1;
         end
         if (drop_word && (o_drop_count != {DROP_W{1'b1}})) begin
            o_drop_count <= o_drop_count + DROP_W'(1);
         end
      end
   end

   assign debug = {26'd0, o_frame_valid, o_rfifo_strobe, o_rfifo_activate,
                   left_pending, state};

endmodule

// File: tb/tb_i2s_reader_frame_assembler.sv
// Directed bench for the frame assembler: a behavioural ping-pong FIFO read
// port feeds both a 24-bit and a 16-bit instance; captured frames are checked.
module tb_i2s_reader_frame_assembler;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_enable;
   logic        i_rfifo_ready;
   logic [23:0] i_rfifo_size;
   logic [31:0] i_rfifo_data;
   logic        i_frame_ready;

   logic        act, strobe, fv;
   logic [23:0] left, right;
   logic [31:0] fc, dbg;
   logic [15:0] dc;

   logic        act16, strobe16, fv16;
   logic [15:0] left16, right16;
   logic [31:0] fc16, dbg16;
   logic [15:0] dc16;

   int total = 0;
   int bad   = 0;

   logic [31:0] mem [0:15];
   int          rd_idx;
   logic        act_q;
   int          strobe_cnt;
   logic [47:0] frames [$];

   always #5 clk = ~clk;

   i2s_reader_frame_assembler #(.OUT_WIDTH(24), .DROP_W(16)) dut (
      .clk(clk), .rst(rst), .i_enable(i_enable), .i_rfifo_ready(i_rfifo_ready),
      .o_rfifo_activate(act), .i_rfifo_size(i_rfifo_size), .o_rfifo_strobe(strobe),
      .i_rfifo_data(i_rfifo_data), .o_frame_valid(fv), .i_frame_ready(i_frame_ready),
      .o_left(left), .o_right(right), .o_frame_count(fc), .o_drop_count(dc),
      .debug(dbg)
   );

   i2s_reader_frame_assembler #(.OUT_WIDTH(16), .DROP_W(16)) dut16 (
      .clk(clk), .rst(rst), .i_enable(i_enable), .i_rfifo_ready(i_rfifo_ready),
      .o_rfifo_activate(act16), .i_rfifo_size(i_rfifo_size), .o_rfifo_strobe(strobe16),
      .i_rfifo_data(i_rfifo_data), .o_frame_valid(fv16), .i_frame_ready(i_frame_ready),
      .o_left(left16), .o_right(right16), .o_frame_count(fc16), .o_drop_count(dc16),
      .debug(dbg16)
   );

   // FIFO read port: first word appears the cycle after activate rises,
   // each following word the cycle after a strobe.
   always @(posedge clk) begin
      if (!rst) begin
         act_q        <= 1'b0;
         rd_idx       <= 0;
         strobe_cnt   <= 0;
         i_rfifo_data <= 32'd0;
      end else begin
         act_q <= act;
         if (act && !act_q) begin
            i_rfifo_data <= mem[0];
            rd_idx       <= 1;
            strobe_cnt   <= 0;
         end else if (strobe) begin
            i_rfifo_data <= mem[rd_idx[3:0]];
            rd_idx       <= rd_idx + 1;
            strobe_cnt   <= strobe_cnt + 1;
         end
      end
   end

   always @(posedge clk) begin
      if (rst && fv && i_frame_ready) frames.push_back({left, right});
   end

   task automatic reset_dut();
      rst           = 1'b0;
      i_enable      = 1'b0;
      i_rfifo_ready = 1'b0;
      i_rfifo_size  = 24'd0;
      i_frame_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst      = 1'b1;
      i_enable = 1'b1;
      @(negedge clk);
   endtask

   task automatic wait_act(input logic level, input string tag);
      int n = 0;
      while (act !== level && n < 200) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (act !== level) begin
         bad++;
         $display("[TB] FAIL %s: activate=%b required %b within 200 cycles", tag, act, level);
      end
   endtask

   task automatic run_buffer(input int size, input string tag);
      i_rfifo_size  = 24'(size);
      i_rfifo_ready = 1'b1;
      wait_act(1'b1, {tag, "_grant"});
      i_rfifo_ready = 1'b0;
      wait_act(1'b0, {tag, "_release"});
   endtask

   task automatic test_reset();
      rst = 1'b0;
      i_enable = 1'b0;
      i_rfifo_ready = 1'b0;
      i_rfifo_size = 24'd0;
      i_frame_ready = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({act, strobe, fv, left, right, fc, dc, dbg} !== '0) begin
         bad++;
         $display("[TB] FAIL reset_state: act=%b strobe=%b fv=%b l=%h r=%h fc=%0d dc=%0d dbg=%h required all zero",
                  act, strobe, fv, left, right, fc, dc, dbg);
      end
      reset_dut();
   endtask

   task automatic test_basic_pairs();
      int start;
      reset_dut();
      i_frame_ready = 1'b1;
      mem[0] = 32'h0000_0011; mem[1] = 32'h8000_0022;
      mem[2] = 32'h0000_0033; mem[3] = 32'h8000_0044;
      start = frames.size();
      run_buffer(4, "t1");
      total++;
      if (strobe_cnt != 4) begin
         bad++;
         $display("[TB] FAIL t1_strobes: got %0d required 4", strobe_cnt);
      end
      repeat (2) @(negedge clk);
      total++;
      if (frames.size() - start != 2 || frames[start] !== 48'h000011_000022 ||
          frames[start+1] !== 48'h000033_000044) begin
         bad++;
         $display("[TB] FAIL t1_frames: got %0d frames required 2 (11,22),(33,44)", frames.size() - start);
      end
      total++;
      if (fc !== 32'd2 || dc !== 16'd0) begin
         bad++;
         $display("[TB] FAIL t1_counts: fc=%0d dc=%0d required fc=2 dc=0", fc, dc);
      end
   endtask

   task automatic test_backpressure();
      int start;
      reset_dut();
      i_frame_ready = 1'b0;
      mem[0] = 32'h0000_0011; mem[1] = 32'h8000_0022;
      mem[2] = 32'h0000_0033; mem[3] = 32'h8000_0044;
      start = frames.size();
      i_rfifo_size  = 24'd4;
      i_rfifo_ready = 1'b1;
      wait_act(1'b1, "t2_grant");
      i_rfifo_ready = 1'b0;
      repeat (10) @(negedge clk);
      total++;
      if (strobe_cnt != 3 || strobe !== 1'b0) begin
         bad++;
         $display("[TB] FAIL t2_stall: strobes=%0d strobe=%b required 3 and 0", strobe_cnt, strobe);
      end
      total++;
      if (fv !== 1'b1 || left !== 24'h11 || right !== 24'h22 || fc !== 32'd0) begin
         bad++;
         $display("[TB] FAIL t2_held: fv=%b l=%h r=%h fc=%0d required 1 11 22 0", fv, left, right, fc);
      end
      i_frame_ready = 1'b1;
      wait_act(1'b0, "t2_release");
      repeat (3) @(negedge clk);
      total++;
      if (frames.size() - start != 2 || frames[start] !== 48'h000011_000022 ||
          frames[start+1] !== 48'h000033_000044 || fc !== 32'd2) begin
         bad++;
         $display("[TB] FAIL t2_order: frames=%0d fc=%0d required 2 in order", frames.size() - start, fc);
      end
   endtask

   task automatic test_orphans();
      int start;
      reset_dut();
      i_frame_ready = 1'b1;
      mem[0] = 32'h8000_0001; mem[1] = 32'h0000_0002;
      mem[2] = 32'h0000_0003; mem[3] = 32'h8000_0004;
      start = frames.size();
      run_buffer(4, "t3");
      repeat (2) @(negedge clk);
      total++;
      if (dc !== 16'd2) begin
         bad++;
         $display("[TB] FAIL t3_drops: got %0d required 2", dc);
      end
      total++;
      if (frames.size() - start != 1 || frames[start] !== 48'h000003_000004 || fc !== 32'd1) begin
         bad++;
         $display("[TB] FAIL t3_frame: frames=%0d fc=%0d required one frame (3,4)", frames.size() - start, fc);
      end
   endtask

   task automatic test_span_buffers();
      int start;
      reset_dut();
      i_frame_ready = 1'b1;
      start = frames.size();
      mem[0] = 32'h00AA_AAAA;
      run_buffer(1, "t4a");
      total++;
      if (dbg[2] !== 1'b1 || fv !== 1'b0) begin
         bad++;
         $display("[TB] FAIL t4_pending: pending=%b fv=%b required 1 0", dbg[2], fv);
      end
      mem[0] = 32'hFFBB_BBBB;
      run_buffer(1, "t4b");
      repeat (3) @(negedge clk);
      total++;
      if (frames.size() - start != 1 || frames[start] !== 48'hAAAAAA_BBBBBB ||
          dc !== 16'd0 || fc !== 32'd1) begin
         bad++;
         $display("[TB] FAIL t4_span: frames=%0d dc=%0d fc=%0d required 1 0 1", frames.size() - start, dc, fc);
      end
   endtask

   task automatic test_width_and_empty();
      reset_dut();
      i_frame_ready = 1'b0;
      mem[0] = 32'h0012_3456; mem[1] = 32'h8065_4321;
      run_buffer(2, "t5");
      total++;
      if (fv16 !== 1'b1 || left16 !== 16'h1234 || right16 !== 16'h6543) begin
         bad++;
         $display("[TB] FAIL t5_narrow: fv=%b l=%h r=%h required 1 1234 6543", fv16, left16, right16);
      end
      total++;
      if (left !== 24'h123456 || right !== 24'h654321) begin
         bad++;
         $display("[TB] FAIL t5_wide: l=%h r=%h required 123456 654321", left, right);
      end
      i_rfifo_size  = 24'd0;
      i_rfifo_ready = 1'b1;
      wait_act(1'b1, "t5_empty_grant");
      i_rfifo_ready = 1'b0;
      @(negedge clk);
      total++;
      if (act !== 1'b0 || act16 !== 1'b0 || strobe_cnt != 0 || strobe16 !== 1'b0 ||
          dbg[1:0] !== 2'd0 || dbg16[1:0] !== 2'd0) begin
         bad++;
         $display("[TB] FAIL t5_empty: act=%b strobes=%0d state=%0d required 0 0 0", act, strobe_cnt, dbg[1:0]);
      end
      total++;
      if (fc16 !== 32'd0 || dc16 !== 16'd0 || fv !== 1'b1) begin
         bad++;
         $display("[TB] FAIL t5_held: fc16=%0d dc16=%0d fv=%b required 0 0 1", fc16, dc16, fv);
      end
      i_frame_ready = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_abort_and_reset();
      int n = 0;
      reset_dut();
      i_frame_ready = 1'b1;
      mem[0] = 32'h8000_0001; mem[1] = 32'h0000_0002;
      mem[2] = 32'h8000_0003; mem[3] = 32'h0000_0004;
      mem[4] = 32'h8000_0005; mem[5] = 32'h0000_0006;
      mem[6] = 32'h8000_0007; mem[7] = 32'h0000_0008;
      i_rfifo_size  = 24'd8;
      i_rfifo_ready = 1'b1;
      wait_act(1'b1, "t6_grant");
      i_rfifo_ready = 1'b0;
      while (strobe_cnt != 2 && n < 50) begin
         @(negedge clk);
         n++;
      end
      i_enable = 1'b0;
      @(negedge clk);
      total++;
      if (act !== 1'b0 || dbg[1:0] !== 2'd0 || dbg[2] !== 1'b0 || strobe_cnt != 2 || dc !== 16'd1) begin
         bad++;
         $display("[TB] FAIL t6_abort: act=%b state=%0d pend=%b strobes=%0d dc=%0d required 0 0 0 2 1",
                  act, dbg[1:0], dbg[2], strobe_cnt, dc);
      end
      rst = 1'b0;
      @(negedge clk);
      total++;
      if (act !== 1'b0 || fv !== 1'b0 || fc !== 32'd0 || dc !== 16'd0 || dbg !== 32'd0) begin
         bad++;
         $display("[TB] FAIL t6_reset: act=%b fv=%b fc=%0d dc=%0d dbg=%h required all zero",
                  act, fv, fc, dc, dbg);
      end
      rst = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 32'd0;
      test_reset();
      test_basic_pairs();
      test_backpressure();
      test_orphans();
      test_span_buffers();
      test_width_and_empty();
      test_abort_and_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
